// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Streams a contiguous, possibly wrapping range of register-file entries out
// over a valid/ready interface.  One register is read per READ cycle through a
// combinational read port. The captured word is then held in SEND until the
// consumer takes it.  At most one word is emitted every two cycles.
//
// Optional feature (macro REG_DUMP_CKSUM_EN):
//   When defined, the module keeps a mod-2^DATA_W sum of every accepted
//   register word. After the last register it appends one extra word carrying
//   that sum, with dout_addr = 0 and dout_last = 1. The last register word then
//   has dout_last = 0.
//   When undefined, no accumulator or CKSUM state is built.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle dump request, honoured only when idle
//   start_addr  in   first register of the range (sampled with start)
//   end_addr    in   last register of the range (sampled with start)
//   raddr       out  register-file read address (always equals current addr)
//   rdata       in   combinational register-file read data for raddr
//   dout        out  streamed word
//   dout_addr   out  register index of dout (0 for the checksum word)
//   dout_valid  out  dout / dout_addr / dout_last are valid
//   dout_ready  in   consumer accepts the word when valid and ready are high
//   dout_last   out  final word of the dump
//   busy        out  dump in progress
//   done        out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND  = 3'd2,
`ifdef REG_DUMP_CKSUM_EN
        CKSUM = 3'd4,
`endif
        DONE  = 3'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] r_end_addr;
    logic [ADDR_W-1:0] w_end_addr_next;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_dout_next;
    logic [ADDR_W-1:0] r_dout_addr;
    logic [ADDR_W-1:0] w_dout_addr_next;
    logic              r_dout_valid;
    logic              w_dout_valid_next;
    logic              r_dout_last;
    logic              w_dout_last_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_at_end;
`ifdef REG_DUMP_CKSUM_EN
    logic [DATA_W-1:0] r_cksum;
    logic [DATA_W-1:0] w_cksum_next;
`endif

    // All outputs come straight from registers.
    assign raddr      = r_addr;
    assign dout       = r_dout;
    assign dout_addr  = r_dout_addr;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = r_busy;
    assign done       = r_done;

    // Range termination is an address match, so a wrapping range ends naturally.
    assign w_at_end = (r_addr == r_end_addr);

    // Next-state and next-register-value logic for the dump sequencer.
    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_end_addr_next   = r_end_addr;
        w_dout_next       = r_dout;
        w_dout_addr_next  = r_dout_addr;
        w_dout_valid_next = 1'b0;
        w_dout_last_next  = 1'b0;
        w_busy_next       = r_busy;
        w_done_next       = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
        w_cksum_next      = r_cksum;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next    = READ;
                    w_addr_next     = start_addr;
                    w_end_addr_next = end_addr;
                    w_busy_next     = 1'b1;
`ifdef REG_DUMP_CKSUM_EN
                    w_cksum_next    = {DATA_W{1'b0}};
`endif
                end else begin
                    w_busy_next     = 1'b0;
                end
            end
            READ: begin
                // Capture the combinational read data; it appears one cycle later.
                w_state_next      = SEND;
                w_dout_next       = rdata;
                w_dout_addr_next  = r_addr;
                w_dout_valid_next = 1'b1;
`ifdef REG_DUMP_CKSUM_EN
                w_dout_last_next  = 1'b0;
`else
                w_dout_last_next  = w_at_end;
`endif
                w_busy_next       = 1'b1;
            end
            SEND: begin
                if (dout_ready) begin
`ifdef REG_DUMP_CKSUM_EN
                    w_cksum_next = r_cksum + r_dout;
`endif
                    if (w_at_end) begin
`ifdef REG_DUMP_CKSUM_EN
                        // Present the running sum, including this final word.
                        w_state_next      = CKSUM;
                        w_dout_next       = r_cksum + r_dout;
                        w_dout_addr_next  = {ADDR_W{1'b0}};
                        w_dout_valid_next = 1'b1;
                        w_dout_last_next  = 1'b1;
                        w_busy_next       = 1'b1;
`else
                        w_state_next      = DONE;
                        w_busy_next       = 1'b0;
                        w_done_next       = 1'b1;
`endif
                    end else begin
                        // Increment wraps naturally at the address width.
                        w_state_next = READ;
                        w_addr_next  = r_addr + ADDR_W'(1);
                        w_busy_next  = 1'b1;
                    end
                end else begin
                    w_dout_valid_next = 1'b1;
                    w_dout_last_next  = r_dout_last;
                    w_busy_next       = 1'b1;
                end
            end
`ifdef REG_DUMP_CKSUM_EN
            CKSUM: begin
                if (dout_ready) begin
                    w_state_next = DONE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_dout_valid_next = 1'b1;
                    w_dout_last_next  = 1'b1;
                    w_busy_next       = 1'b1;
                end
            end
`endif
            DONE: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= {ADDR_W{1'b0}};
            r_end_addr   <= {ADDR_W{1'b0}};
            r_dout       <= {DATA_W{1'b0}};
            r_dout_addr  <= {ADDR_W{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
            r_cksum      <= {DATA_W{1'b0}};
`endif
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_end_addr   <= w_end_addr_next;
            r_dout       <= w_dout_next;
            r_dout_addr  <= w_dout_addr_next;
            r_dout_valid <= w_dout_valid_next;
            r_dout_last  <= w_dout_last_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
`ifdef REG_DUMP_CKSUM_EN
            r_cksum      <= w_cksum_next;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for reg_dump_reader.  Stimulus pushes hand-computed
// expected words into a queue.  A negedge monitor pops and compares each word
// the consumer accepts. Register file model: x[i] = i*16.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_addr = 5'd0;
    logic [4:0]  end_addr = 5'd0;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] dout;
    logic [4:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = -10;
    logic        prev_stall = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_d = 32'd0;
    logic [4:0]  prev_a = 5'd0;
    logic        prev_l = 1'b0;

    reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .raddr(raddr), .rdata(rdata), .dout(dout),
        .dout_addr(dout_addr), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb rdata = regs[raddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Register word: in checksum builds the checksum word is last instead.
    task automatic push_reg(input logic [4:0] a, input logic [31:0] d, input logic l);
        exp_t e;
        e.a = a;
        e.d = d;
`ifdef REG_DUMP_CKSUM_EN
        e.l = 1'b0 & l;
`else
        e.l = l;
`endif
        exp_q.push_back(e);
    endtask

    task automatic push_ck(input logic [31:0] sum);
`ifdef REG_DUMP_CKSUM_EN
        exp_t e;
        e.a = 5'd0;
        e.d = sum;
        e.l = 1'b1;
        exp_q.push_back(e);
`else
        if (sum === 32'hxxxx_xxxx) $display("unreachable");
`endif
    endtask

    // Monitor: stall stability, read/send spacing, and scoreboard compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", 64'(dout_valid), 64'd1);
                chk("stall_dout", 64'(dout), 64'(prev_d));
                chk("stall_addr", 64'(dout_addr), 64'(prev_a));
                chk("stall_last", 64'(dout_last), 64'(prev_l));
            end
`ifndef REG_DUMP_CKSUM_EN
            if (prev_acc) chk("gap_after_accept", 64'(dout_valid), 64'd0);
`endif
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got addr=%0d data=0x%0h, required none", dout_addr, dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_addr", 64'(dout_addr), 64'(mon_e.a));
                    chk("word_data", 64'(dout), 64'(mon_e.d));
                    chk("word_last", 64'(dout_last), 64'(mon_e.l));
                    if (dout_last) last_acc_cyc = cyc;
                end
            end
        end
        prev_stall = !rst && dout_valid && !dout_ready;
        prev_acc   = !rst && dout_valid && dout_ready;
        prev_d     = dout;
        prev_a     = dout_addr;
        prev_l     = dout_last;
    end

    task automatic do_start(input logic [4:0] s, input logic [4:0] e);
        @(posedge clk); #1;
        start = 1'b1; start_addr = s; end_addr = e;
        @(posedge clk); #1;
        start = 1'b0; start_addr = ~s; end_addr = ~e;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("read_latency_valid_low", 64'(dout_valid), 64'd0);
    endtask

    task automatic wait_valid();
        logic seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dout_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("valid_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(seen), 64'd1);
        if (seen) begin
            chk("done_latency", 64'(cyc), 64'(last_acc_cyc + 1));
            chk("busy_low_in_done", 64'(busy), 64'd0);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_dout_addr", 64'(dout_addr), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_last", 64'(dout_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        #1 rst = 1'b0;

        // 3..5, consumer always ready
        dout_ready = 1'b1;
        push_reg(5'd3, 32'h30, 1'b0);
        push_reg(5'd4, 32'h40, 1'b0);
        push_reg(5'd5, 32'h50, 1'b1);
        push_ck(32'hC0);
        do_start(5'd3, 5'd5);
        wait_done();

        // 30..1 wraps through 31 to 0
        push_reg(5'd30, 32'h1E0, 1'b0);
        push_reg(5'd31, 32'h1F0, 1'b0);
        push_reg(5'd0, 32'h0, 1'b0);
        push_reg(5'd1, 32'h10, 1'b1);
        push_ck(32'h3E0);
        do_start(5'd30, 5'd1);
        wait_done();

        // 7..7 single word, consumer stalls five cycles
        @(posedge clk); #1 dout_ready = 1'b0;
        push_reg(5'd7, 32'h70, 1'b1);
        push_ck(32'h70);
        do_start(5'd7, 5'd7);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall7_valid", 64'(dout_valid), 64'd1);
            chk("stall7_dout", 64'(dout), 64'h70);
        end
        @(posedge clk); #1 dout_ready = 1'b1;
        wait_done();

        // 1..3 (checksum case when enabled)
        push_reg(5'd1, 32'h10, 1'b0);
        push_reg(5'd2, 32'h20, 1'b0);
        push_reg(5'd3, 32'h30, 1'b1);
        push_ck(32'h60);
        do_start(5'd1, 5'd3);
        wait_done();

        // start while busy is ignored and keeps the latched range
        @(posedge clk); #1 dout_ready = 1'b0;
        push_reg(5'd10, 32'hA0, 1'b0);
        push_reg(5'd11, 32'hB0, 1'b1);
        push_ck(32'h150);
        do_start(5'd10, 5'd11);
        wait_valid();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 5'd20; end_addr = 5'd25;
        @(posedge clk); #1;
        start = 1'b0;
        dout_ready = 1'b1;
        wait_done();

        // 5..4 covers all 32 registers
        for (int i = 0; i < 32; i++) begin
            push_reg(5'((5 + i) % 32), 32'(((5 + i) % 32) * 16), (i == 31) ? 1'b1 : 1'b0);
        end
        push_ck(32'h1F00);
        do_start(5'd5, 5'd4);
        wait_done();

        // Reset during SEND of the second word of 0..31
        @(posedge clk); #1 dout_ready = 1'b0;
        push_reg(5'd0, 32'h0, 1'b0);
        do_start(5'd0, 5'd31);
        wait_valid();
        @(posedge clk); #1 dout_ready = 1'b1;
        @(posedge clk); #1 dout_ready = 1'b0;
        begin
            logic seen2 = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (dout_valid && dout_addr == 5'd1) begin
                    seen2 = 1'b1;
                    break;
                end
            end
            chk("second_word_timeout", 64'(seen2), 64'd1);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(dout_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_dout", 64'(dout), 64'd0);
        chk("midrst_raddr", 64'(raddr), 64'd0);
        chk("midrst_scoreboard", 64'(exp_q.size()), 64'd0);
        #1 rst = 1'b0;
        dout_ready = 1'b1;
        push_reg(5'd0, 32'h0, 1'b1);
        push_ck(32'h0);
        do_start(5'd0, 5'd0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("idle_valid_end", 64'(dout_valid), 64'd0);
        chk("idle_busy_end", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump; ignored unless idle.
REQ-006 SHALL have port start_addr  input  ADDR_W  first register to dump; sampled with start.
REQ-007 SHALL have port end_addr  input  ADDR_W  last register to dump; sampled with start.
REQ-008 SHALL have port raddr  output  ADDR_W  read address to the register-file read port.
REQ-009 SHALL have port rdata  input  DATA_W  combinational register-file read data for raddr.
REQ-010 SHALL have port dout  output  DATA_W  streamed word.
REQ-011 SHALL have port dout_addr  output  ADDR_W  register index of dout.
REQ-012 SHALL have port dout_valid  output  1  dout/dout_addr/dout_last valid.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts the word when dout_valid and dout_ready are both high.
REQ-014 SHALL have port dout_last  output  1  marks the final word of the dump.
REQ-015 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE completes.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, READ, SEND, DONE (plus CKSUM per REQ-030).
REQ-018 IDLE: on start, SHALL latch start_addr into addr, latch end_addr, clear word count, and go to READ; busy rises next cycle.
REQ-019 READ: SHALL drive raddr=addr, capture rdata into dout and addr into dout_addr at the clock edge, and go to SEND; latency is 1 cycle from READ entry to dout_valid.
REQ-020 SEND: SHALL hold dout_valid high with dout, dout_addr and dout_last stable until dout_ready is high.
REQ-021 On acceptance in SEND with addr != end: SHALL increment addr modulo 2^ADDR_W (31 wraps to 0) and return to READ.
REQ-022 On acceptance in SEND with addr == end: SHALL go to DONE (or CKSUM when enabled).
REQ-023 The words emitted SHALL be ((end-start) mod 32)+1; start==end emits one word; end<start wraps through register 31 to 0.
REQ-024 dout_last SHALL be high only on the final word of the dump.
REQ-025 DONE: SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-026 Max throughput SHALL be one word per two cycles; dout_valid SHALL be low in READ, DONE, and IDLE.
REQ-027 start while busy SHALL be ignored and SHALL NOT alter the latched range.
REQ-028 raddr SHALL equal addr in every state.

Reset
REQ-029 While rst is high at a rising edge (including mid-dump), the FSM SHALL enter IDLE with addr=0, raddr=0, dout=0, dout_addr=0, dout_valid=0, dout_last=0, busy=0, done=0, checksum=0; no partial word SHALL be presented afterwards.

Configuration
REQ-030 With REG_DUMP_CKSUM_EN defined: SHALL accumulate the mod-2^DATA_W sum of all accepted register words, and after the last register is accepted SHALL enter CKSUM, presenting dout=sum, dout_addr=0, dout_valid=1, dout_last=1 until accepted, then DONE; the register word SHALL then have dout_last=0.
REQ-031 Without REG_DUMP_CKSUM_EN: no accumulator or CKSUM state SHALL exist; dout_last SHALL mark the last register word.

Verification
REQ-032 Regs preloaded x[i]=i*16; start with 3..5, dout_ready=1 -> words 0x30,0x40,0x50 with dout_addr 3,4,5; dout_last only on 0x50; done pulses once.
REQ-033 start with 30..1 -> dout_addr sequence 30,31,0,1 (x0 reads 0); 4 words total.
REQ-034 start with 7..7, dout_ready held low 5 cycles -> dout_valid high, dout=0x70 stable all 5 cycles; accepted on the first ready cycle; done the cycle after DONE entry.
REQ-035 Assert rst during SEND of the 2nd word of 0..31 -> next cycle dout_valid=0, busy=0, done=0; a new start 0..0 then yields one word 0x0.
REQ-036 With REG_DUMP_CKSUM_EN, dump 1..3 of 0x10,0x20,0x30 -> four words, last is dout=0x60, dout_addr=0, dout_last=1; without the macro, three words with dout_last on 0x30.
